// File: rtl/fetch_unit.sv
// RV32I instruction fetch front-end: fetch PC, credit-limited imem requests,
// in-order instruction FIFO toward decode, flush and drop on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic          grant;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_aligned;

    // Credit covers both in-flight and buffered fetches, so a full FIFO
    // can never receive a response it has no room for.
    assign credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req         = !rst && !redirect_valid
                              && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr        = fetch_pc;
    assign redirect_aligned = redirect_pc & ~32'h3;

    assign grant = imem_req && imem_gnt;
    assign push  = imem_rvalid && !redirect_valid && (drop == '0);
    assign pop   = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = !rst && (fifo_count != '0);
    assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (redirect_valid) begin
                fetch_pc   <= redirect_aligned;
                resp_pc    <= redirect_aligned;
                drop       <= outstanding - CW'(imem_rvalid);
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid && (drop != '0))
                    drop <= drop - 1'b1;
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule
